dac_seg_driver: RTL and testbench
=================================

Name: dac_seg_driver

Overview:
Parametrised, clocked successor of the DAC driver cell. Accepts a segmented code (binary LSBs plus thermometer-encoded MSBs) and produces registered, complementary switch controls for the current-steering array. Adds a power-up sequencing FSM, a supply-fault latch, and optional dynamic element matching (DEM) rotation of the thermometer segments. It sits between the digital datapath and the analog switch array.

Parameters:
BIN_W, 8, number of binary LSB bits driven directly.
THERM_SEL_W, 4, number of MSB code bits decoded to thermometer; THERM_W = 2**THERM_SEL_W - 1 segments (15 by default).
WAKE_CYCLES, 4, number of cycles spent in WAKE before outputs go live (must be at least 1).

Ports:
clk  in  1  clock (one clock domain).
rst_n  in  1  asynchronous, active-low reset.
code_in  in  BIN_W+THERM_SEL_W  segmented code; upper THERM_SEL_W bits are the MSBs, lower BIN_W bits are the LSBs.
code_valid  in  1  qualifies code_in; sampled only in ACTIVE.
pdb  in  1  power-down bar; 0 forces OFF.
supply_ok  in  1  synchronous supply-good flag from the analog monitor.
dem_en  in  1  1 = rotate thermometer segments; 0 = fixed fill from bit 0.
binout  out  BIN_W  binary switch control.
binoutb  out  BIN_W  complement of binout.
thermout  out  THERM_W  thermometer switch control.
thermoutb  out  THERM_W  complement of thermout.
ready  out  1  high only in ACTIVE.
fault  out  1  sticky supply fault.

Behaviour:
- Reset (asynchronous assert, synchronous release): state=OFF; binout=0, binoutb='1; thermout=0, thermoutb='1; ready=0; fault=0; DEM pointer ptr=0; pipeline registers=0.
- Invariant in every state and cycle: binoutb==~binout and thermoutb==~thermout. Both are registered in the same flop stage.
- FSM states: OFF, WAKE, ACTIVE, FAULT. Priority is pdb=0 first, then supply fault, then the normal transition.
  - Any state with pdb=0 -> OFF at the next edge. This also clears fault.
  - OFF with pdb=1 and supply_ok=1 -> WAKE. The wake counter loads WAKE_CYCLES-1.
  - WAKE: the counter decrements each cycle; at 0 -> ACTIVE. ptr is cleared on entry to ACTIVE.
  - WAKE or ACTIVE with supply_ok=0 -> FAULT. fault is set at the same edge.
  - FAULT stays in FAULT while pdb=1, even if supply_ok returns.
- Outputs in OFF, WAKE and FAULT are parked: binout=0, thermout=0, complements all-ones. Pipeline stages are flushed to 0.
- ready is registered and equals (state==ACTIVE).
- Datapath (ACTIVE only), two-stage pipeline:
  - S1: when code_valid=1, register code_in. When code_valid=0, S1 holds its value.
  - S2: register binout = S1 LSBs. Let m = S1 MSB value (0..THERM_W).
  - dem_en=0: thermout = (1<<m)-1.
  - dem_en=1: thermout has m ones at positions ptr, ptr+1, ... modulo THERM_W. ptr <= (ptr+m) mod THERM_W, computed from the pre-update ptr.
  - ptr advances only on cycles where S2 loads a new sample, i.e. S1 was loaded in the previous cycle.
- Latency: code_valid sampled at edge N gives binout/thermout updated at edge N+1 (two register stages, visible after edge N+1).
- Boundaries:
  - m=0: thermout=0 and ptr is unchanged.
  - m=THERM_W: thermout all-ones and ptr is unchanged, since the mod wraps to the same position.
  - Wrap-around of ptr past THERM_W-1 folds to bit 0.
  - Simultaneous pdb=0 and supply_ok=0: go to OFF; fault stays 0.
  - Leaving ACTIVE mid-stream parks the outputs at the next edge; in-flight samples are discarded.

Decomposition:
- Package dac_seg_pkg holds:
  - the state enum (OFF, WAKE, ACTIVE, FAULT);
  - a function therm_w(sel_w) returning 2**sel_w-1;
  - a function to compute the pointer width ($clog2(THERM_W)).
- One sub-module, dac_therm_rotator: combinational. Inputs m, ptr, dem_en; outputs the THERM_W-bit thermometer pattern and next_ptr. The top holds the FSM, counter, pipeline registers and ptr register.

Test Plan:
Defaults (BIN_W=8, THERM_SEL_W=4, WAKE_CYCLES=4) unless stated; thermometer values are shown as 15-bit hex.
1. Assert rst_n=0 mid-cycle -> immediately binout=8'h00, binoutb=8'hFF, thermout=0x0000, thermoutb=0x7FFF, ready=0, fault=0.
2. Release reset, then pdb=1 and supply_ok=1 -> WAKE after 1 edge; ready=1 exactly 4 edges later. code_valid pulses during WAKE have no effect (outputs stay parked).
3. ACTIVE, dem_en=0, code_in=12'h3A5 with code_valid for 1 cycle -> two edges later binout=8'hA5, binoutb=8'h5A, thermout=0x0007; value holds while code_valid=0.
4. dem_en=1, consecutive MSBs 5, 5, 6 -> thermout 0x001F, 0x03E0, 0x7C01 (wraps through bit 0); final ptr=1.
5. MSB=15 -> thermout=0x7FFF with ptr unchanged; MSB=0 -> thermout=0x0000.
6. supply_ok=0 in ACTIVE -> next edge fault=1, ready=0, outputs parked. supply_ok=1 again -> still FAULT. pdb=0 -> OFF with fault=0. pdb=1 -> wake sequence repeats with ptr=0.

Source files
------------

// File: rtl/dac_seg_pkg.sv
// ---------------------------------------------------------------------------
// dac_seg_pkg : shared FSM states and width helpers for dac_seg_driver
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package dac_seg_pkg;

   typedef enum logic [1:0] {
      ST_OFF    = 2'd0,
      ST_WAKE   = 2'd1,
      ST_ACTIVE = 2'd2,
      ST_FAULT  = 2'd3
   } state_t;

   function automatic int therm_w(input int sel_w);
      return (1 << sel_w) - 1;
   endfunction

   // A single segment still needs a 1-bit pointer register.
   function automatic int ptr_w(input int tw);
      return (tw > 1) ? $clog2(tw) : 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/dac_seg_driver_if.sv
// ---------------------------------------------------------------------------
// dac_seg_driver_if : code input, control and switch-control bundle
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface dac_seg_driver_if #(
   parameter int BIN_W       = 8,
   parameter int THERM_SEL_W = 4
);
   localparam int THERM_W = dac_seg_pkg::therm_w(THERM_SEL_W);

   logic [BIN_W+THERM_SEL_W-1:0] code_in;
   logic                         code_valid;
   logic                         pdb;
   logic                         supply_ok;
   logic                         dem_en;
   logic [BIN_W-1:0]             binout;
   logic [BIN_W-1:0]             binoutb;
   logic [THERM_W-1:0]           thermout;
   logic [THERM_W-1:0]           thermoutb;
   logic                         ready;
   logic                         fault;

   modport master (
      output code_in, code_valid, pdb, supply_ok, dem_en,
      input  binout, binoutb, thermout, thermoutb, ready, fault
   );

   modport slave (
      input  code_in, code_valid, pdb, supply_ok, dem_en,
      output binout, binoutb, thermout, thermoutb, ready, fault
   );

endinterface

`default_nettype wire

// File: rtl/dac_therm_rotator.sv
// ---------------------------------------------------------------------------
// dac_therm_rotator : thermometer fill with optional DEM rotation from ptr
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module dac_therm_rotator
   import dac_seg_pkg::*;
#(
   parameter  int THERM_SEL_W = 4,
   localparam int THERM_W     = therm_w(THERM_SEL_W),
   localparam int PTR_W       = ptr_w(THERM_W)
) (
   input  logic [THERM_SEL_W-1:0] m,
   input  logic [PTR_W-1:0]       ptr,
   input  logic                   dem_en,
   output logic [THERM_W-1:0]     therm,
   output logic [PTR_W-1:0]       next_ptr
);

   // Wide enough to hold i + THERM_W and ptr + m without overflow.
   localparam int SUM_W = THERM_SEL_W + 1;

   logic [THERM_W-1:0] w_fill;
   logic [THERM_W-1:0] w_rot;
   logic [SUM_W-1:0]   w_sum;
   logic [SUM_W-1:0]   w_wrap;

   for (genvar i = 0; i < THERM_W; i++) begin : g_bit
      logic [SUM_W-1:0] w_off;
      // Distance of bit i from ptr, walking upward modulo THERM_W.
      assign w_off = (SUM_W'(i) >= SUM_W'(ptr)) ? SUM_W'(i) - SUM_W'(ptr)
                                                : SUM_W'(i) + SUM_W'(THERM_W) - SUM_W'(ptr);
      assign w_fill[i] = SUM_W'(i) < SUM_W'(m);
      assign w_rot[i]  = w_off < SUM_W'(m);
   end

   assign w_sum    = SUM_W'(ptr) + SUM_W'(m);
   assign w_wrap   = (w_sum >= SUM_W'(THERM_W)) ? w_sum - SUM_W'(THERM_W) : w_sum;
   assign therm    = dem_en ? w_rot : w_fill;
   assign next_ptr = dem_en ? PTR_W'(w_wrap) : ptr;

endmodule

`default_nettype wire

// File: rtl/dac_seg_driver.sv
// ---------------------------------------------------------------------------
// dac_seg_driver : sequenced, registered complementary switch driver
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module dac_seg_driver
   import dac_seg_pkg::*;
#(
   parameter int BIN_W       = 8,
   parameter int THERM_SEL_W = 4,
   parameter int WAKE_CYCLES = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   dac_seg_driver_if.slave  bus
);

   localparam int THERM_W = therm_w(THERM_SEL_W);
   localparam int PTR_W   = ptr_w(THERM_W);
   localparam int CODE_W  = BIN_W + THERM_SEL_W;
   localparam int CNT_W   = $clog2(WAKE_CYCLES + 1);

   state_t             r_state;
   logic [CNT_W-1:0]   r_wake_cnt;
   logic [CODE_W-1:0]  r_s1;
   logic               r_s1_new;
   logic [PTR_W-1:0]   r_ptr;
   logic [BIN_W-1:0]   r_binout;
   logic [BIN_W-1:0]   r_binoutb;
   logic [THERM_W-1:0] r_thermout;
   logic [THERM_W-1:0] r_thermoutb;
   logic               r_ready;
   logic               r_fault;

   logic [THERM_W-1:0] w_therm;
   logic [PTR_W-1:0]   w_next_ptr;

   dac_therm_rotator #(
      .THERM_SEL_W (THERM_SEL_W)
   ) u_rotator (
      .m        (r_s1[CODE_W-1:BIN_W]),
      .ptr      (r_ptr),
      .dem_en   (bus.dem_en),
      .therm    (w_therm),
      .next_ptr (w_next_ptr)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_OFF;
         r_wake_cnt  <= '0;
         r_s1        <= '0;
         r_s1_new    <= 1'b0;
         r_ptr       <= '0;
         r_binout    <= '0;
         r_binoutb   <= '1;
         r_thermout  <= '0;
         r_thermoutb <= '1;
         r_ready     <= 1'b0;
         r_fault     <= 1'b0;
      end else begin
         // Parked/flushed by default; only a cycle that stays in ACTIVE overrides.
         r_s1        <= '0;
         r_s1_new    <= 1'b0;
         r_binout    <= '0;
         r_binoutb   <= '1;
         r_thermout  <= '0;
         r_thermoutb <= '1;
         r_ready     <= 1'b0;

         if (!bus.pdb) begin
            r_state <= ST_OFF;
            r_fault <= 1'b0;
         end else if (!bus.supply_ok && (r_state == ST_WAKE || r_state == ST_ACTIVE)) begin
            r_state <= ST_FAULT;
            r_fault <= 1'b1;
         end else begin
            case (r_state)
               ST_OFF: begin
                  if (bus.supply_ok) begin
                     r_state    <= ST_WAKE;
                     r_wake_cnt <= CNT_W'(WAKE_CYCLES - 1);
                  end
               end
               ST_WAKE: begin
                  if (r_wake_cnt == '0) begin
                     r_state <= ST_ACTIVE;
                     r_ready <= 1'b1;
                     r_ptr   <= '0;
                  end else begin
                     r_wake_cnt <= r_wake_cnt - CNT_W'(1);
                  end
               end
               ST_ACTIVE: begin
                  r_ready  <= 1'b1;
                  r_s1_new <= bus.code_valid;
                  r_s1     <= bus.code_valid ? bus.code_in : r_s1;
                  if (r_s1_new) begin
                     r_binout    <= r_s1[BIN_W-1:0];
                     r_binoutb   <= ~r_s1[BIN_W-1:0];
                     r_thermout  <= w_therm;
                     r_thermoutb <= ~w_therm;
                     r_ptr       <= w_next_ptr;
                  end else begin
                     r_binout    <= r_binout;
                     r_binoutb   <= r_binoutb;
                     r_thermout  <= r_thermout;
                     r_thermoutb <= r_thermoutb;
                  end
               end
               ST_FAULT: begin
                  r_state <= ST_FAULT;
               end
               default: begin
                  r_state <= ST_OFF;
               end
            endcase
         end
      end
   end

   assign bus.binout    = r_binout;
   assign bus.binoutb   = r_binoutb;
   assign bus.thermout  = r_thermout;
   assign bus.thermoutb = r_thermoutb;
   assign bus.ready     = r_ready;
   assign bus.fault     = r_fault;

endmodule

`default_nettype wire

// File: tb/tb_dac_seg_driver.sv
// ---------------------------------------------------------------------------
// tb_dac_seg_driver : directed and randomized checks against a cycle model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_dac_seg_driver;

   localparam int BIN_W       = 8;
   localparam int THERM_SEL_W = 4;
   localparam int WAKE_CYCLES = 4;
   localparam int THERM_W     = 15;

   localparam int M_OFF  = 0;
   localparam int M_WAKE = 1;
   localparam int M_ACT  = 2;
   localparam int M_FLT  = 3;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_checks = 0;
   int   n_errors = 0;

   dac_seg_driver_if #(.BIN_W(BIN_W), .THERM_SEL_W(THERM_SEL_W)) bus ();

   dac_seg_driver #(
      .BIN_W       (BIN_W),
      .THERM_SEL_W (THERM_SEL_W),
      .WAKE_CYCLES (WAKE_CYCLES)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Reference model state
   int            m_mode      = M_OFF;
   int            m_wake_seen = 0;
   int            m_ptr       = 0;
   logic [11:0]   m_s1        = '0;
   bit            m_s1_new    = 1'b0;
   logic [7:0]    m_bin       = '0;
   logic [14:0]   m_therm     = '0;
   bit            m_fault     = 1'b0;

   function automatic logic [14:0] model_therm(int m, int p, bit dem);
      logic [14:0] t;
      t = '0;
      for (int k = 0; k < m; k++) begin
         if (dem) t[(p + k) % THERM_W] = 1'b1;
         else     t[k] = 1'b1;
      end
      return t;
   endfunction

   task automatic model_reset();
      m_mode = M_OFF; m_wake_seen = 0; m_ptr = 0;
      m_s1 = '0; m_s1_new = 1'b0; m_bin = '0; m_therm = '0; m_fault = 1'b0;
   endtask

   task automatic model_step();
      int nm;
      int sm;
      nm = m_mode;
      if (!bus.pdb) begin
         nm = M_OFF; m_fault = 1'b0;
      end else if (!bus.supply_ok && (m_mode == M_WAKE || m_mode == M_ACT)) begin
         nm = M_FLT; m_fault = 1'b1;
      end else if (m_mode == M_OFF && bus.supply_ok) begin
         nm = M_WAKE; m_wake_seen = 0;
      end else if (m_mode == M_WAKE) begin
         m_wake_seen++;
         if (m_wake_seen == WAKE_CYCLES) begin
            nm = M_ACT; m_ptr = 0;
         end
      end
      if (m_mode == M_ACT && nm == M_ACT) begin
         if (m_s1_new) begin
            sm      = int'(m_s1[11:8]);
            m_bin   = m_s1[7:0];
            m_therm = model_therm(sm, m_ptr, bus.dem_en);
            if (bus.dem_en) m_ptr = (m_ptr + sm) % THERM_W;
         end
         m_s1_new = bus.code_valid;
         if (bus.code_valid) m_s1 = bus.code_in;
      end else begin
         m_bin = '0; m_therm = '0; m_s1 = '0; m_s1_new = 1'b0;
      end
      m_mode = nm;
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) model_reset();
      else        model_step();
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Advance to the next falling edge and compare every output with the model.
   task automatic step();
      logic [7:0]  eb;
      logic [14:0] et;
      @(negedge clk);
      eb = ~m_bin;
      et = ~m_therm;
      chk("binout",    32'(bus.binout),    32'(m_bin));
      chk("binoutb",   32'(bus.binoutb),   32'(eb));
      chk("thermout",  32'(bus.thermout),  32'(m_therm));
      chk("thermoutb", 32'(bus.thermoutb), 32'(et));
      chk("ready",     32'(bus.ready),     32'(m_mode == M_ACT));
      chk("fault",     32'(bus.fault),     32'(m_fault));
   endtask

   task automatic send(input logic [11:0] code);
      bus.code_in    = code;
      bus.code_valid = 1'b1;
      step();
      bus.code_valid = 1'b0;
      step();
   endtask

   task automatic wake_up(input string tag);
      int first;
      first = 0;
      bus.pdb       = 1'b1;
      bus.supply_ok = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         step();
         if (bus.ready && first == 0) first = i;
         bus.code_in    = 12'hFFF;
         bus.code_valid = (i < 3);
      end
      bus.code_valid = 1'b0;
      chk(tag, 32'(first), 32'd5);
      chk({tag, "_parked"}, 32'(bus.binout), 32'd0);
   endtask

   initial begin
      bus.code_in    = '0;
      bus.code_valid = 1'b0;
      bus.pdb        = 1'b0;
      bus.supply_ok  = 1'b0;
      bus.dem_en     = 1'b0;
      step();
      step();
      rst_n = 1'b1;
      step();

      wake_up("wake_lat");

      send(12'h3A5);
      chk("t3_bin",   32'(bus.binout),   32'h0A5);
      chk("t3_binb",  32'(bus.binoutb),  32'h05A);
      chk("t3_therm", 32'(bus.thermout), 32'h0007);
      step();
      step();
      chk("t3_hold",  32'(bus.thermout), 32'h0007);

      bus.dem_en     = 1'b1;
      bus.code_valid = 1'b1;
      bus.code_in    = 12'h512;
      step();
      bus.code_in    = 12'h534;
      step();
      chk("t4_a", 32'(bus.thermout), 32'h001F);
      bus.code_in    = 12'h656;
      step();
      chk("t4_b", 32'(bus.thermout), 32'h03E0);
      bus.code_valid = 1'b0;
      step();
      chk("t4_c", 32'(bus.thermout), 32'h7C01);
      send(12'h100);
      chk("t4_ptr1", 32'(bus.thermout), 32'h0002);

      send(12'hF00);
      chk("t5_full", 32'(bus.thermout), 32'h7FFF);
      send(12'h100);
      chk("t5_ptr_kept", 32'(bus.thermout), 32'h0004);
      send(12'h0AB);
      chk("t5_zero", 32'(bus.thermout), 32'h0000);

      bus.supply_ok = 1'b0;
      step();
      chk("t6_fault", 32'(bus.fault), 32'd1);
      chk("t6_ready", 32'(bus.ready), 32'd0);
      chk("t6_park",  32'(bus.thermoutb), 32'h7FFF);
      bus.supply_ok = 1'b1;
      step();
      step();
      chk("t6_sticky", 32'(bus.fault), 32'd1);
      bus.pdb = 1'b0;
      step();
      chk("t6_clear", 32'(bus.fault), 32'd0);
      wake_up("rewake_lat");
      send(12'h300);
      chk("t6_ptr0", 32'(bus.thermout), 32'h0007);

      bus.pdb       = 1'b0;
      bus.supply_ok = 1'b0;
      step();
      chk("both_low_fault", 32'(bus.fault), 32'd0);
      chk("both_low_ready", 32'(bus.ready), 32'd0);
      wake_up("wake3_lat");

      send(12'h2FF);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_bin",    32'(bus.binout),    32'h00);
      chk("rst_binb",   32'(bus.binoutb),   32'hFF);
      chk("rst_therm",  32'(bus.thermout),  32'h0000);
      chk("rst_thermb", 32'(bus.thermoutb), 32'h7FFF);
      chk("rst_ready",  32'(bus.ready),     32'd0);
      chk("rst_fault",  32'(bus.fault),     32'd0);
      step();
      rst_n = 1'b1;

      bus.pdb       = 1'b1;
      bus.supply_ok = 1'b1;
      for (int c = 0; c < 3000; c++) begin
         step();
         bus.pdb        = ($urandom % 64) != 0;
         bus.supply_ok  = ($urandom % 48) != 0;
         bus.code_valid = $urandom % 2;
         bus.code_in    = 12'($urandom);
         if ($urandom % 16 == 0) bus.dem_en = ~bus.dem_en;
      end
      step();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
